pll_lock_monitor: RTL and testbench

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

---
 rtl/pll_lock_mon_pkg.sv | 19 +
 rtl/lock_sync_2ff.sv | 26 ++
 rtl/pll_lock_monitor.sv | 158 +++++++++++++++
 tb/tb_pll_lock_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_mon_pkg.sv
// Shared types and constants for the PLL lock monitor: FSM state encoding
// and the width of the filter/hold counter.
package pll_lock_mon_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_FILTER    = 2'd1;
    localparam logic [1:0] ST_HOLD      = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    typedef enum logic [1:0] {
        WAIT_LOCK = ST_WAIT_LOCK,
        FILTER    = ST_FILTER,
        HOLD      = ST_HOLD,
        RUN       = ST_RUN
    } state_t;

endpackage

// File: rtl/lock_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCKED flag into the
// system clock domain; both flops clear on reset.
module lock_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic ff1_r;
    logic ff2_r;

    // Synchronizer chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_r <= 1'b0;
            ff2_r <= 1'b0;
        end else begin
            ff1_r <= d;
            ff2_r <= ff1_r;
        end
    end

    assign q = ff2_r;

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: filters LOCKED, sequences the downstream reset and counts
// lock losses. The loss counter is built only when PLL_LOCK_MON_LOSS_CNT_EN is defined.
module pll_lock_monitor
    import pll_lock_mon_pkg::*;
#(
    parameter int LOCK_FILTER = 16,
    parameter int RST_HOLD    = 8,
    parameter int LOSS_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  I_LOCKED,
    input  logic                  I_PWRDWN,
    input  logic                  I_CLEAR,
    output logic                  O_RST,
    output logic                  O_STABLE,
    output logic [1:0]            O_STATE,
    output logic [LOSS_CNT_W-1:0] O_LOSS_CNT
);

    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             locked_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             loss_evt_s;

    lock_sync_2ff u_lock_sync (
        .clk (CLK),
        .rst (RST),
        .d   (I_LOCKED),
        .q   (locked_s)
    );

    // State and shared filter/hold counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= WAIT_LOCK;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; power-down overrides every other transition
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        loss_evt_s  = 1'b0;
        if (I_PWRDWN) begin
            state_nxt_s = WAIT_LOCK;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt_s = FILTER;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = WAIT_LOCK;
                    end
                end
                FILTER: begin
                    if (!locked_s) begin
                        state_nxt_s = WAIT_LOCK;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == FILTER_LAST) begin
                        state_nxt_s = HOLD;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!locked_s) begin
                        state_nxt_s = WAIT_LOCK;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == HOLD_LAST) begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_nxt_s = WAIT_LOCK;
                        loss_evt_s  = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                default: begin
                    state_nxt_s = WAIT_LOCK;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs decoded straight from the state register
    always_comb begin
        O_RST    = 1'b1;
        O_STABLE = 1'b0;
        case (state_r)
            RUN: begin
                O_RST    = 1'b0;
                O_STABLE = 1'b1;
            end
            default: begin
                O_RST    = 1'b1;
                O_STABLE = 1'b0;
            end
        endcase
    end

    assign O_STATE = state_r;

`ifdef PLL_LOCK_MON_LOSS_CNT_EN
    localparam logic [LOSS_CNT_W-1:0] LOSS_ZERO = {LOSS_CNT_W{1'b0}};
    localparam logic [LOSS_CNT_W-1:0] LOSS_ONE  = LOSS_CNT_W'(1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX  = {LOSS_CNT_W{1'b1}};

    logic [LOSS_CNT_W-1:0] loss_cnt_r;

    // Saturating loss counter; a clear coinciding with a loss leaves one count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            loss_cnt_r <= LOSS_ZERO;
        end else if (loss_evt_s) begin
            if (I_CLEAR) begin
                loss_cnt_r <= LOSS_ONE;
            end else if (loss_cnt_r != LOSS_MAX) begin
                loss_cnt_r <= loss_cnt_r + LOSS_ONE;
            end else begin
                loss_cnt_r <= loss_cnt_r;
            end
        end else if (I_CLEAR) begin
            loss_cnt_r <= LOSS_ZERO;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign O_LOSS_CNT = loss_cnt_r;
`else
    logic unused_s;
    assign unused_s   = I_CLEAR ^ loss_evt_s;
    assign O_LOSS_CNT = {LOSS_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: directed scenarios plus random
// LOCKED/PWRDWN/CLEAR stimulus against a streak-length reference model.
module tb_pll_lock_monitor;

    localparam int LF       = 16;
    localparam int RH       = 8;
    localparam int LW       = 4;
    localparam int RUN_N    = LF + RH + 1;
    localparam int LOSS_SAT = (1 << LW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          I_LOCKED = 1'b0;
    logic          I_PWRDWN = 1'b0;
    logic          I_CLEAR = 1'b0;
    logic          O_RST;
    logic          O_STABLE;
    logic [1:0]    O_STATE;
    logic [LW-1:0] O_LOSS_CNT;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: m_n = consecutive edges that saw synchronized lock
    int m_n    = 0;
    int m_loss = 0;
    bit m_l1   = 1'b0;
    bit m_l2   = 1'b0;

    pll_lock_monitor #(.LOCK_FILTER(LF), .RST_HOLD(RH), .LOSS_CNT_W(LW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .I_LOCKED   (I_LOCKED),
        .I_PWRDWN   (I_PWRDWN),
        .I_CLEAR    (I_CLEAR),
        .O_RST      (O_RST),
        .O_STABLE   (O_STABLE),
        .O_STATE    (O_STATE),
        .O_LOSS_CNT (O_LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (m_n == 0)            return 0;
        else if (m_n <= LF)      return 1;
        else if (m_n <= LF + RH) return 2;
        else                     return 3;
    endfunction

    function automatic int exp_loss(input int k);
`ifdef PLL_LOCK_MON_LOSS_CNT_EN
        return (k > LOSS_SAT) ? LOSS_SAT : k;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_n = 0; m_loss = 0; m_l1 = 1'b0; m_l2 = 1'b0;
    endtask

    task automatic model_edge();
        bit ls;
        bit evt;
        ls   = m_l2;
        m_l2 = m_l1;
        m_l1 = I_LOCKED;
        evt  = 1'b0;
        if (I_PWRDWN) m_n = 0;
        else if (ls) begin
            if (m_n < 1000) m_n++;
        end else begin
            evt = (m_n >= RUN_N);
            m_n = 0;
        end
`ifdef PLL_LOCK_MON_LOSS_CNT_EN
        if (evt) m_loss = I_CLEAR ? 1 : ((m_loss < LOSS_SAT) ? m_loss + 1 : LOSS_SAT);
        else if (I_CLEAR) m_loss = 0;
`endif
    endtask

    task automatic check_all();
        int s;
        s = exp_state();
        check_eq("state",    O_STATE,    s);
        check_eq("o_rst",    O_RST,      (s != 3) ? 1 : 0);
        check_eq("o_stable", O_STABLE,   (s == 3) ? 1 : 0);
        check_eq("loss_cnt", O_LOSS_CNT, m_loss);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        I_LOCKED = 1'b0; I_PWRDWN = 1'b0; I_CLEAR = 1'b0;
        #2 RST = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic drop(input int n);
        I_LOCKED = 1'b0;
        repeat (n) step();
    endtask

    // Hold LOCKED high and record the edges where FILTER is entered from
    // WAIT_LOCK, HOLD/RUN first appear and O_RST first falls
    task automatic lock_until_run(output int e_f, output int e_h, output int e_r, output int e_rst);
        int prev;
        prev = O_STATE; e_f = 0; e_h = 0; e_r = 0; e_rst = 0;
        I_LOCKED = 1'b1;
        for (int e = 1; e <= 40 && e_r == 0; e++) begin
            step();
            if (prev == 0 && O_STATE == 2'd1) e_f = e;
            if (e_h == 0 && O_STATE == 2'd2)  e_h = e;
            if (e_r == 0 && O_STATE == 2'd3)  e_r = e;
            if (e_rst == 0 && O_RST == 1'b0)  e_rst = e;
            prev = O_STATE;
        end
    endtask

    initial begin
        int ef, eh, er, erst, remain;
        model_reset();
        #1;
        check_eq("reset_state",  O_STATE,    0);
        check_eq("reset_o_rst",  O_RST,      1);
        check_eq("reset_stable", O_STABLE,   0);
        check_eq("reset_loss",   O_LOSS_CNT, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Clean lock
        lock_until_run(ef, eh, er, erst);
        check_eq("clean_filter_edge", ef,   3);
        check_eq("clean_hold_edge",   eh,   3 + LF);
        check_eq("clean_run_edge",    er,   3 + LF + RH);
        check_eq("clean_rst_fall",    erst, 3 + LF + RH);

        // Glitch during filtering restarts the whole sequence
        do_reset();
        I_LOCKED = 1'b1;
        repeat (10) step();
        drop(1);
        lock_until_run(ef, eh, er, erst);
        check_eq("glitch_filter_edge", ef, 3);
        check_eq("glitch_hold_edge",   eh, 3 + LF);
        check_eq("glitch_run_edge",    er, 3 + LF + RH);
        check_eq("glitch_loss",        O_LOSS_CNT, 0);

        // Repeated losses in RUN saturate the counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            lock_until_run(ef, eh, er, erst);
            check_eq("relock_run_edge", er, 3 + LF + RH);
            drop(3);
            check_eq("loss_seq", O_LOSS_CNT, exp_loss(i + 1));
        end

        // Power-down in RUN: back to WAIT_LOCK on the next edge, no loss
        lock_until_run(ef, eh, er, erst);
        I_PWRDWN = 1'b1;
        step();
        I_PWRDWN = 1'b0;
        check_eq("pwrdwn_state", O_STATE,    0);
        check_eq("pwrdwn_o_rst", O_RST,      1);
        check_eq("pwrdwn_loss",  O_LOSS_CNT, exp_loss(17));
        drop(3);

        // Clear alone, then clear coinciding with a loss
        I_CLEAR = 1'b1;
        step();
        I_CLEAR = 1'b0;
        check_eq("clear_alone", O_LOSS_CNT, 0);
        for (int i = 0; i < 5; i++) begin
            lock_until_run(ef, eh, er, erst);
            drop(3);
        end
        check_eq("loss_five", O_LOSS_CNT, exp_loss(5));
        lock_until_run(ef, eh, er, erst);
        drop(2);
        I_CLEAR = 1'b1;
        step();
        I_CLEAR = 1'b0;
        check_eq("clear_with_loss", O_LOSS_CNT, exp_loss(1));
        drop(1);

        // Asynchronous reset during HOLD
        I_LOCKED = 1'b1;
        for (int i = 0; i < 30 && O_STATE != 2'd2; i++) step();
        step();
        step();
        check_eq("pre_reset_hold", O_STATE, 2);
        #2 RST = 1'b1;
        #1;
        check_eq("async_rst_state",  O_STATE,    0);
        check_eq("async_rst_o_rst",  O_RST,      1);
        check_eq("async_rst_stable", O_STABLE,   0);
        check_eq("async_rst_loss",   O_LOSS_CNT, 0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        lock_until_run(ef, eh, er, erst);
        check_eq("post_reset_run_edge", er, 3 + LF + RH);

        // Random LOCKED runs with sporadic power-down and clear
        remain = 0;
        for (int c = 0; c < 3000; c++) begin
            if (remain == 0) begin
                I_LOCKED = ($urandom_range(0, 3) != 0);
                remain   = I_LOCKED ? $urandom_range(1, 60) : $urandom_range(1, 5);
            end
            remain--;
            I_PWRDWN = ($urandom_range(0, 49) == 0);
            I_CLEAR  = ($urandom_range(0, 39) == 0);
            step();
        end
        I_PWRDWN = 1'b0;
        I_CLEAR  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
